// File: rtl/ks_voice_ctrl_if.sv
// Handshake between the voice sequencer and the Karplus-Strong engine.
// master = sequencer side, slave = engine side.
interface ks_voice_ctrl_if;
    logic               ks_start;
    logic               ks_newnote;
    logic [10:0]        ks_length;
    logic signed [23:0] ks_dout;
    logic               ks_dout_valid;

    modport master (
        output ks_start,
        output ks_newnote,
        output ks_length,
        input  ks_dout,
        input  ks_dout_valid
    );

    modport slave (
        input  ks_start,
        input  ks_newnote,
        input  ks_length,
        output ks_dout,
        output ks_dout_valid
    );
endinterface

// File: rtl/ks_voice_ctrl.sv
// Per-sample sequencer for the single-voice Karplus-Strong engine: pluck/continue/silence,
// velocity gain, linear note-off release, one gain-scaled sample per accepted tick.
module ks_voice_ctrl #(
    parameter int unsigned TIMEOUT = 2047,
    parameter int unsigned REL_DIV = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_tick,
    input  logic               note_on,
    input  logic               note_off,
    input  logic [6:0]         note,
    input  logic [6:0]         velocity,
    ks_voice_ctrl_if.master    eng,
    output logic signed [23:0] sample_out,
    output logic               sample_valid,
    output logic               active,
    output logic               overrun
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, MUL, OUT} state_t;

    // Delay length table, evaluated at elaboration: round(48 kHz / f(note)), clamped to 2..1745.
    function automatic logic [10:0] len_of(input int n);
        real period;
        int  r;
        if (n < 21) return 11'd1745;
        period = 48000.0 / (440.0 * (2.0 ** (real'(n - 69) / 12.0)));
        r = $rtoi(period + 0.5);
        if (r < 2) r = 2;
        else if (r > 1745) r = 1745;
        return 11'(r);
    endfunction

    logic [10:0] len_lut [128];
    for (genvar i = 0; i < 128; i++) begin : g_lut
        assign len_lut[i] = len_of(i);
    end

    state_t             state;
    logic               pend;
    logic [6:0]         pend_note;
    logic [6:0]         pend_vel;
    logic [6:0]         cur_note;
    logic [7:0]         gain;
    logic               rel;
    logic [5:0]         rel_cnt;
    logic [TW-1:0]      tmo;
    logic signed [23:0] dout_q;
    logic signed [32:0] prod;
    logic               pluck;

    assign prod   = dout_q * $signed({1'b0, gain});
    assign pluck  = (state == IDLE) && sample_tick && pend;
    assign active = (gain != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pend           <= 1'b0;
            pend_note      <= '0;
            pend_vel       <= '0;
            cur_note       <= '0;
            gain           <= '0;
            rel            <= 1'b0;
            rel_cnt        <= '0;
            tmo            <= '0;
            dout_q         <= '0;
            eng.ks_start   <= 1'b0;
            eng.ks_newnote <= 1'b0;
            eng.ks_length  <= '0;
            sample_out     <= '0;
            sample_valid   <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sample_valid <= 1'b0;
                    if (sample_tick) begin
                        if (pend) begin
                            eng.ks_length  <= len_lut[pend_note];
                            cur_note       <= pend_note;
                            gain           <= {pend_vel, 1'b1};
                            rel            <= 1'b0;
                            rel_cnt        <= '0;
                            pend           <= 1'b0;
                            eng.ks_newnote <= 1'b1;
                            eng.ks_start   <= 1'b1;
                            state          <= ISSUE;
                        end else if (gain != '0) begin
                            eng.ks_newnote <= 1'b0;
                            eng.ks_start   <= 1'b1;
                            state          <= ISSUE;
                        end else begin
                            sample_out   <= '0;
                            sample_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    eng.ks_start <= 1'b0;
                    tmo          <= '0;
                    state        <= WAIT;
                end
                WAIT: begin
                    if (eng.ks_dout_valid) begin
                        dout_q <= eng.ks_dout;
                        state  <= MUL;
                    end else if (tmo == TW'(TIMEOUT - 1)) begin
                        overrun      <= 1'b1;
                        sample_out   <= '0;
                        sample_valid <= 1'b1;
                        state        <= OUT;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                MUL: begin
                    sample_out   <= 24'(prod >>> 8);
                    sample_valid <= 1'b1;
                    state        <= OUT;
                end
                OUT: begin
                    sample_valid <= 1'b0;
                    if (rel) begin
                        if (rel_cnt == 6'(REL_DIV - 1)) begin
                            rel_cnt <= '0;
                            if (gain != '0) gain <= gain - 1'b1;
                        end else begin
                            rel_cnt <= rel_cnt + 1'b1;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Capture after the IDLE decision so a same-cycle note_on re-arms pend for the next tick.
            if (note_on) begin
                pend      <= 1'b1;
                pend_note <= note;
                pend_vel  <= velocity;
            end
            if (note_off && !note_on && !pluck && note == cur_note && gain != '0)
                rel <= 1'b1;
            if (sample_tick && state != IDLE)
                overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ks_voice_ctrl.sv
// Directed + randomized bench for ks_voice_ctrl against a per-tick behavioural voice model.
module tb_ks_voice_ctrl;
    localparam int TIMEOUT = 2047;
    localparam int REL_DIV = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               sample_tick = 1'b0;
    logic               note_on = 1'b0;
    logic               note_off = 1'b0;
    logic [6:0]         note = '0;
    logic [6:0]         velocity = '0;
    logic signed [23:0] sample_out;
    logic               sample_valid;
    logic               active;
    logic               overrun;

    ks_voice_ctrl_if eng();

    ks_voice_ctrl #(.TIMEOUT(TIMEOUT), .REL_DIV(REL_DIV)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .note_on(note_on), .note_off(note_off),
        .note(note), .velocity(velocity), .eng(eng), .sample_out(sample_out),
        .sample_valid(sample_valid), .active(active), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Voice model, one step per tick
    int m_pend, m_pnote, m_pvel, m_cur, m_gain, m_rel, m_relcnt, m_len, m_ovr;

    function automatic int lenref(input int n);
        real l;
        int  r;
        if (n < 21) return 1745;
        l = (48000.0 / 440.0) * (2.0 ** ((69 - n) / 12.0));
        r = $rtoi(l + 0.5);
        if (r < 2) r = 2;
        if (r > 1745) r = 1745;
        return r;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_pnote = 0; m_pvel = 0; m_cur = 0; m_gain = 0;
        m_rel = 0; m_relcnt = 0; m_len = 0; m_ovr = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_note_on(input int n, input int v);
        @(negedge clk);
        note_on = 1'b1; note = 7'(n); velocity = 7'(v);
        @(negedge clk);
        note_on = 1'b0;
        m_pend = 1; m_pnote = n; m_pvel = v;
    endtask

    task automatic do_note_off(input int n);
        @(negedge clk);
        note_off = 1'b1; note = 7'(n);
        @(negedge clk);
        note_off = 1'b0;
        if (n == m_cur && m_gain > 0) m_rel = 1;
    endtask

    task automatic do_on_off_same(input int n, input int v);
        @(negedge clk);
        note_on = 1'b1; note_off = 1'b1; note = 7'(n); velocity = 7'(v);
        @(negedge clk);
        note_on = 1'b0; note_off = 1'b0;
        m_pend = 1; m_pnote = n; m_pvel = v;
    endtask

    task automatic release_step();
        if (m_rel != 0) begin
            m_relcnt++;
            if (m_relcnt == REL_DIV) begin
                m_relcnt = 0;
                if (m_gain > 0) m_gain--;
            end
        end
    endtask

    // One sample tick; timeout=1 withholds the engine sample and injects a tick during WAIT.
    task automatic tick_run(input logic signed [23:0] d, input int dly, input bit timeout);
        int     newnote;
        bit     silent;
        longint e;
        int     cnt;
        silent = 0; newnote = 0;
        if (m_pend != 0) begin
            newnote = 1; m_cur = m_pnote; m_gain = 2 * m_pvel + 1;
            m_rel = 0; m_relcnt = 0; m_pend = 0; m_len = lenref(m_cur);
        end else if (m_gain == 0) begin
            silent = 1;
        end
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        if (silent) begin
            chk("silent_start", 32'(eng.ks_start), 32'd0);
            chk("silent_valid", 32'(sample_valid), 32'd1);
            chk("silent_out", {8'h0, sample_out}, 32'd0);
        end else begin
            chk("start", 32'(eng.ks_start), 32'd1);
            chk("newnote", 32'(eng.ks_newnote), 32'(newnote));
            chk("length", 32'(eng.ks_length), 32'(m_len));
            @(negedge clk);
            chk("start_pulse", 32'(eng.ks_start), 32'd0);
            if (!timeout) begin
                repeat (dly) @(negedge clk);
                eng.ks_dout = d; eng.ks_dout_valid = 1'b1;
                @(negedge clk);
                eng.ks_dout_valid = 1'b0;
                chk("valid_early", 32'(sample_valid), 32'd0);
                @(negedge clk);
                e = (longint'(d) * longint'(m_gain)) >>> 8;
                chk("valid", 32'(sample_valid), 32'd1);
                chk("out", {8'h0, sample_out}, {8'h0, 24'(e)});
            end else begin
                cnt = 1;
                sample_tick = 1'b1;
                @(negedge clk); cnt++;
                sample_tick = 1'b0;
                m_ovr = 1;
                chk("ovr_tick", 32'(overrun), 32'd1);
                while (!sample_valid && cnt < TIMEOUT + 20) begin
                    @(negedge clk); cnt++;
                end
                chk("tmo_cycles", 32'(cnt), 32'(TIMEOUT + 1));
                chk("tmo_out", {8'h0, sample_out}, 32'd0);
            end
            release_step();
        end
        @(negedge clk);
        chk("valid_drop", 32'(sample_valid), 32'd0);
        chk("active", 32'(active), 32'(m_gain > 0));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        eng.ks_dout = '0;
        eng.ks_dout_valid = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out", {8'h0, sample_out}, 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_start", 32'(eng.ks_start), 32'd0);
        chk("rst_newnote", 32'(eng.ks_newnote), 32'd0);
        chk("rst_len", 32'(eng.ks_length), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;

        // Asynchronous reset while waiting on the engine
        do_note_on(69, 127);
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        chk("pre_rst_start", 32'(eng.ks_start), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_len", 32'(eng.ks_length), 32'd0);
        chk("arst_newnote", 32'(eng.ks_newnote), 32'd0);
        chk("arst_active", 32'(active), 32'd0);
        @(negedge clk); rst = 1'b0;
        model_reset();
        tick_run(24'sh000123, 0, 0);

        // A4 at full velocity
        do_note_on(69, 127);
        tick_run(24'sh100000, 3, 0);
        chk("len69", 32'(eng.ks_length), 32'd109);
        chk("out_a4", {8'h0, sample_out}, 32'h000F_F000);

        // Continue, then low-note clamp
        tick_run(24'shF80000, 1, 0);
        chk("len69_hold", 32'(eng.ks_length), 32'd109);
        do_note_on(20, 64);
        tick_run(24'sh7FFFFF, 0, 0);
        chk("len20", 32'(eng.ks_length), 32'd1745);

        // Randomized notes, note-offs and engine samples
        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 3) do_note_on(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
            else if (r == 3) do_note_off(($urandom_range(0, 1) == 1) ? m_cur : int'($urandom_range(0, 127)));
            tick_run(24'($urandom), int'($urandom_range(0, 15)), 0);
        end

        // note_on beats same-cycle note_off; note_off for another note is ignored
        do_note_on(50, 100);
        tick_run(24'sh100000, 2, 0);
        do_on_off_same(50, 90);
        do_note_off(51);
        for (int i = 0; i < 6; i++) tick_run(24'sh100000, 0, 0);
        chk("no_release_out", {8'h0, sample_out}, 32'h000B_5000);

        // Full release from gain 255
        do_note_on(60, 127);
        tick_run(24'sh400000, 0, 0);
        do_note_off(60);
        for (int i = 0; i < 510; i++) tick_run(24'($urandom), int'($urandom_range(0, 3)), 0);
        chk("released_active", 32'(active), 32'd0);
        tick_run(24'sh400000, 0, 0);

        // Engine timeout with a tick arriving during WAIT
        do_note_on(64, 10);
        tick_run(24'sh010000, 0, 0);
        tick_run(24'sh000000, 0, 1);
        tick_run(24'sh200000, 4, 0);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
